// File: rtl/angle_convert.sv
// Integer degrees to signed fixed-point radians, with optional reduction into [0,359].
// Valid/ready on both sides; one request in flight at a time.
module angle_convert #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_deg,
  input  logic             in_wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_rad,
  output logic [INT_W-1:0] out_deg
);

  localparam int CNT_W    = $clog2(INT_W);
  localparam int MOD_W    = INT_W + 9;
  localparam int PROD_W   = INT_W + 3 * FRAC_W + 2;
  localparam int PI_Q     = $rtoi(3.141592653589793 * real'(2 ** FRAC_W) + 0.5);
  localparam int INV180_Q = ((2 ** FRAC_W) + 90) / 180;
  localparam longint K_L  = longint'(PI_Q) * longint'(INV180_Q);
  localparam logic signed [PROD_W-1:0] K_S = PROD_W'(K_L);

  typedef enum logic [1:0] {IDLE, REDUCE, SCALE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [INT_W-1:0]   deg_q;
  logic               wrap_q;
  logic [INT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   rad_q, rad_d;
  logic [INT_W-1:0]   odeg_q;
  logic               valid_q;

  logic               accept;
  logic               hold_done;
  logic [INT_W-1:0]   abs_in;
  logic [MOD_W-1:0]   sub_val;
  logic [MOD_W-1:0]   rem_ext;
  logic [8:0]         r_fix;
  logic [INT_W-1:0]   d;
  logic signed [PROD_W-1:0] d_ext;
  logic signed [PROD_W-1:0] prod;

  assign accept    = in_valid && in_ready;
  assign hold_done = valid_q && out_ready;

  // Unsigned magnitude so that the most negative input reduces correctly
  assign abs_in = in_deg[INT_W-1] ? (-in_deg) : in_deg;

  always_comb begin
    sub_val = MOD_W'(360) << cnt_q;
    rem_ext = MOD_W'(rem_q);
    rem_d   = rem_q;
    if (rem_ext >= sub_val) begin
      rem_d = INT_W'(rem_ext - sub_val);
    end
  end

  always_comb begin
    r_fix = rem_q[8:0];
    if (deg_q[INT_W-1] && (rem_q != '0)) begin
      r_fix = 9'd360 - rem_q[8:0];
    end
    d = wrap_q ? INT_W'(r_fix) : deg_q;
  end

  // Product is wide enough that the shift by FRAC_W before the multiply loses nothing
  always_comb begin
    d_ext = PROD_W'($signed(d));
    prod  = (d_ext <<< FRAC_W) * K_S;
    rad_d = OUT_W'(prod >>> (2 * FRAC_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = in_wrap ? REDUCE : SCALE;
      REDUCE:  if (cnt_q == '0) state_d = SCALE;
      SCALE:   state_d = HOLD;
      HOLD:    if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = valid_q;
    out_rad   = rad_q;
    out_deg   = odeg_q;
  end

  // valid_q lags entry into HOLD by one edge; results stay put after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deg_q   <= '0;
      wrap_q  <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rad_q   <= '0;
      odeg_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        deg_q  <= in_deg;
        wrap_q <= in_wrap;
        rem_q  <= abs_in;
        cnt_q  <= CNT_W'(INT_W - 1);
      end
      if (state_q == REDUCE) begin
        rem_q <= rem_d;
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
      if (state_q == SCALE) begin
        rad_q  <= rad_d;
        odeg_q <= d;
      end
      valid_q <= (state_q == HOLD) && !hold_done;
    end
  end

endmodule

// File: tb/tb_angle_convert.sv
// Directed checks of angle_convert: scaling, wrap reduction, latency, backpressure, reset.
module tb_angle_convert;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_deg;
  logic               in_wrap;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_rad;
  logic signed [15:0] out_deg;

  int n_checks = 0;
  int n_fail   = 0;

  angle_convert #(.INT_W(16), .FRAC_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_deg    (in_deg),
    .in_wrap   (in_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rad   (out_rad),
    .out_deg   (out_deg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag, input int deg, input bit wrap,
                     input int exp_deg, input longint exp_rad, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, in_ready, 1);
    in_valid = 1'b1;
    in_deg   = 16'(deg);
    in_wrap  = wrap;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_deg   = 16'sh5a5a;
    in_wrap  = ~wrap;
    wait_valid(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_deg"}, out_deg, exp_deg);
    check({tag, "_rad"}, out_rad, exp_rad);
    @(posedge clk); #1;
    check({tag, "_drop"}, out_valid, 0);
    check({tag, "_keep"}, out_rad, exp_rad);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_deg    = '0;
    in_wrap   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_rad", out_rad, 0);
    check("rst_deg", out_deg, 0);
    check("rst_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", in_ready, 1);

    run("p90",     90,     0, 90,  102918,  2);
    run("m90",    -90,     0, -90, -102919, 2);
    run("m1",     -1,      0, -1,  -1144,   2);
    run("z0",      0,      0, 0,   0,       2);
    run("wm90",   -90,     1, 270, 308755,  18);
    run("w450",    450,    1, 90,  102918,  18);
    run("wm360",  -360,    1, 0,   0,       18);
    run("wmin",   -32768,  1, 352, 402525,  18);
    run("wmax",    32767,  1, 7,   8004,    18);
    run("wm1",    -1,      1, 359, 410529,  18);
    run("w720",    720,    1, 0,   0,       18);

    // Backpressure: result held, requests dropped while busy
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_deg   = 16'sd180;
    in_wrap  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_lat", lat, 2);
    check("bp_rad", out_rad, 205836);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_deg   = 16'sd90;
      in_wrap  = 1'b0;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_rad", out_rad, 205836);
      check("bp_hold_deg", out_deg, 180);
      check("bp_hold_rdy", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_rdy", in_ready, 1);
    check("bp_idle_rad", out_rad, 205836);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_acc_rdy", in_ready, 0);
    wait_valid(lat);
    check("bp2_lat", lat, 2);
    check("bp2_rad", out_rad, 102918);
    check("bp2_deg", out_deg, 90);
    @(posedge clk); #1;

    // Reset in the middle of a reduction
    @(negedge clk);
    in_valid = 1'b1;
    in_deg   = 16'sd1000;
    in_wrap  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_rad", out_rad, 0);
    check("mrst_deg", out_deg, 0);
    check("mrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_rel_ready", in_ready, 1);
    check("mrst_no_result", out_valid, 0);
    run("post_rst", 180, 0, 180, 205836, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/angle_convert.md
ANGLE_CONVERT -- requirements
Module: angle_convert

Interface
REQ-001 SHALL have parameter INT_W, default 16, giving the signed integer degree input width (legal range 10..30).
REQ-002 SHALL have parameter FRAC_W, default 16, giving the fractional bits of the fixed-point output (legal range 8..24).
REQ-003 SHALL have parameter OUT_W, default 32, giving the signed fixed-point radian output width.
REQ-004 SHALL have port clk  input  1  as the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  as the reset, which is asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  to signal that the request is valid.
REQ-007 SHALL have port in_ready  output  1  to signal that the block can accept a request.
REQ-008 SHALL have port in_deg  input  INT_W  carrying signed integer degrees.
REQ-009 SHALL have port in_wrap  input  1  where 1 reduces the angle into [0,359] before scaling.
REQ-010 SHALL have port out_valid  output  1  to signal that the result is valid.
REQ-011 SHALL have port out_ready  input  1  to signal that the consumer accepts the result.
REQ-012 SHALL have port out_rad  output  OUT_W  carrying signed radians with FRAC_W fractional bits.
REQ-013 SHALL have port out_deg  output  INT_W  carrying the signed degrees actually scaled, after wrap if applied.

Function
REQ-014 SHALL implement FSM states IDLE, REDUCE, SCALE and HOLD.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL define the accept edge as a rising edge with in_valid&&in_ready.
REQ-017 SHALL, on the accept edge, capture in_deg and in_wrap, ignoring later changes to either until the next accept.
REQ-018 SHALL, on the accept edge, go to REDUCE when in_wrap=1, else to SCALE.
REQ-019 SHALL, in REDUCE, compute |deg| mod 360 by restoring shift-subtract.
  - One step per cycle, compare/subtract 360<<i for i=INT_W-1 down to 0.
  - Exactly INT_W cycles.
  - Counter-driven, then go to SCALE.
REQ-020 SHALL, after REDUCE, set remainder r as follows.
  - deg>=0: r unchanged.
  - deg<0 and r!=0: r = 360-r.
  - deg<0 and r==0: r = 0.
REQ-021 SHALL compute |deg| as an INT_W-bit unsigned value, so deg = -2^(INT_W-1) reduces correctly.
REQ-022 SHALL, in SCALE (one cycle), compute out_rad with full-width signed arithmetic and no intermediate truncation.
  - out_rad = ((d<<FRAC_W) * PI_Q * INV180_Q) >>> (2*FRAC_W), keeping the low OUT_W bits.
  - PI_Q = round(pi*2^FRAC_W); INV180_Q = round(2^FRAC_W/180).
  - >>> is an arithmetic shift, i.e. floor toward -inf.
  - d = r when wrap, else captured deg.
REQ-023 SHALL, in SCALE, register out_deg = d and go to HOLD.
REQ-024 SHALL, in HOLD, drive out_valid=1 and hold out_rad and out_deg stable until out_ready=1.
REQ-025 SHALL, on an edge in HOLD with out_ready=1, go to IDLE with out_valid=0.
  - in_ready=1 is asserted on the following cycle.
  - No back-to-back accept in the same edge.
REQ-026 SHALL meet these latencies from accept edge E0.
  - wrap=0: out_valid=1 after edge E0+2.
  - wrap=1: out_valid=1 after edge E0+INT_W+2.
  - Both hold when out_ready is held high.
REQ-027 SHALL retain out_rad and out_deg after the output handshake until the next SCALE; only out_valid drops.
REQ-028 SHALL drop the request when in_valid=1 outside IDLE (in_ready=0).

Reset
REQ-029 SHALL, when rst_n=0, immediately and without a clock set the FSM to IDLE and zero the REDUCE counter.
  - out_valid=0, out_rad=0, out_deg=0.
  - in_ready=1 once rst_n=1.
REQ-030 SHALL, on reset mid-REDUCE, SCALE or HOLD, abort the transaction with no result, and the next accept after release SHALL behave normally.

Verification
REQ-031 SHALL verify FRAC_W=16 scaling: PI_Q=205887, INV180_Q=364.
REQ-032 SHALL verify that wrap=0 with in_deg=90 gives out_rad=102918 and out_deg=90, with out_valid after E0+2.
REQ-033 SHALL verify that wrap=0 with in_deg=-90 gives out_rad=-102919 (floor) and out_deg=-90.
REQ-034 SHALL verify that wrap=1 with in_deg=-90 gives out_deg=270 and out_rad=308755, with out_valid after E0+18 (INT_W=16).
REQ-035 SHALL verify these wrap=1 boundaries.
  - in_deg=450 gives 90 / 102918.
  - in_deg=-360 gives 0 / 0.
  - in_deg=-32768 gives out_deg=352.
REQ-036 SHALL verify backpressure: out_ready held 0 for 10 cycles, with out_valid and data stable and in_ready=0, then out_ready=1 gives IDLE on the next edge and accept two cycles later.
REQ-037 SHALL verify that rst_n pulsed low mid-REDUCE gives all outputs 0 with no clock edge, and that a new 180-degree wrap=0 request then yields out_rad=205836.
